// File: rtl/hazard_ctrl_pkg.sv
// Shared types, opcode constants and source-usage decode for the hazard controller.
package hazard_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_S      = 7'b0100011;
  localparam logic [6:0] OPC_B      = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LD_STALL,
    ST_FLUSH,
    ST_MEM_WAIT
  } hz_state_t;

  // Returns {use_rs1, use_rs2}; opcodes without register sources read nothing.
  function automatic logic [1:0] uses_rs(input logic [6:0] opcode);
    case (opcode)
      OPC_R, OPC_S, OPC_B:            uses_rs = 2'b11;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: uses_rs = 2'b10;
      default:                        uses_rs = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage status in, interlock controls out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             mem_valid;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic             branch_taken;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_bubble;
  logic             flush_ifid;
  logic             flush_exmem;
  logic             pipe_freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             err_timeout;
  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_flush;

  // Pipeline side: reports stage contents, consumes the controls.
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2,
    output ex_valid, ex_rd, ex_reg_write, ex_mem_read,
    output mem_valid, mem_rd, mem_reg_write, branch_taken,
    output wb_valid, wb_rd, wb_reg_write, mem_busy,
    input  pc_en, ifid_en, idex_bubble, flush_ifid, flush_exmem, pipe_freeze,
    input  fwd_a, fwd_b, err_timeout, perf_stall, perf_flush
  );

  // Hazard controller side.
  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2,
    input  ex_valid, ex_rd, ex_reg_write, ex_mem_read,
    input  mem_valid, mem_rd, mem_reg_write, branch_taken,
    input  wb_valid, wb_rd, wb_reg_write, mem_busy,
    output pc_en, ifid_en, idex_bubble, flush_ifid, flush_exmem, pipe_freeze,
    output fwd_a, fwd_b, err_timeout, perf_stall, perf_flush
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// One operand forwarding select; MEM-stage result beats WB, x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       mem_valid,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output fwd_sel_t   sel
);
  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_valid && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs);
  assign wb_hit  = wb_valid && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs);

  always_comb begin
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
    else             sel = FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: forwarding, load-use stall, branch flush, memory-wait freeze.
// Optional build macro HAZARD_PERF_CNT_EN enables the perf_stall/perf_flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [7:0] WAIT_MAX_C = 8'(MEM_WAIT_MAX);

  hz_state_t  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  logic       use_rs1, use_rs2;
  logic       lu, lu_eff;
  fwd_sel_t   fwd_a_raw, fwd_b_raw;

  logic       ctl_pc_en, ctl_ifid_en, ctl_bubble;
  logic       ctl_flush_ifid, ctl_flush_exmem, ctl_freeze;

  assign {use_rs1, use_rs2} = uses_rs(hz.id_opcode);

  assign lu = hz.id_valid && hz.ex_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
              ((use_rs1 && (hz.id_rs1 == hz.ex_rd)) || (use_rs2 && (hz.id_rs2 == hz.ex_rd)));
  // The instruction behind a flushed branch is a squashed slot, so it cannot stall.
  assign lu_eff = lu && (state_q != ST_FLUSH);

  fwd_sel u_fwd_a (
    .rs(hz.id_rs1), .mem_valid(hz.mem_valid), .mem_reg_write(hz.mem_reg_write),
    .mem_rd(hz.mem_rd), .wb_valid(hz.wb_valid), .wb_reg_write(hz.wb_reg_write),
    .wb_rd(hz.wb_rd), .sel(fwd_a_raw)
  );

  fwd_sel u_fwd_b (
    .rs(hz.id_rs2), .mem_valid(hz.mem_valid), .mem_reg_write(hz.mem_reg_write),
    .mem_rd(hz.mem_rd), .wb_valid(hz.wb_valid), .wb_reg_write(hz.wb_reg_write),
    .wb_rd(hz.wb_rd), .sel(fwd_b_raw)
  );

  always_comb begin
    // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned (no latch).
    ctl_pc_en       = 1'b1;
    ctl_ifid_en     = 1'b1;
    ctl_bubble      = 1'b0;
    ctl_flush_ifid  = 1'b0;
    ctl_flush_exmem = 1'b0;
    ctl_freeze      = 1'b0;
    if (rst) begin
      ctl_pc_en       = 1'b0;
      ctl_ifid_en     = 1'b0;
      ctl_bubble      = 1'b1;
      ctl_flush_ifid  = 1'b1;
      ctl_flush_exmem = 1'b1;
    end else if (hz.branch_taken) begin
      ctl_bubble      = 1'b1;
      ctl_flush_ifid  = 1'b1;
      ctl_flush_exmem = 1'b1;
    end else if (hz.mem_busy) begin
      ctl_pc_en   = 1'b0;
      ctl_ifid_en = 1'b0;
      ctl_freeze  = 1'b1;
    end else if (lu_eff) begin
      ctl_pc_en   = 1'b0;
      ctl_ifid_en = 1'b0;
      ctl_bubble  = 1'b1;
    end
  end

  always_comb begin
    state_d    = ST_RUN;
    wait_cnt_d = 8'd0;
    if (hz.branch_taken) begin
      state_d = ST_FLUSH;
    end else if (hz.mem_busy) begin
      state_d    = ST_MEM_WAIT;
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end else if (lu_eff) begin
      state_d = ST_LD_STALL;
    end
    err_d = err_q || (wait_cnt_d >= WAIT_MAX_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of its peers.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign hz.pc_en       = ctl_pc_en;
  assign hz.ifid_en     = ctl_ifid_en;
  assign hz.idex_bubble = ctl_bubble;
  assign hz.flush_ifid  = ctl_flush_ifid;
  assign hz.flush_exmem = ctl_flush_exmem;
  assign hz.pipe_freeze = ctl_freeze;
  assign hz.fwd_a       = rst ? FWD_RF : fwd_a_raw;
  assign hz.fwd_b       = rst ? FWD_RF : fwd_b_raw;
  assign hz.err_timeout = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

  // A bubble without an EX/MEM flush is exactly a load-use stall cycle.
  assign stall_evt = ctl_bubble && !ctl_flush_exmem;
  assign flush_evt = !rst && hz.branch_taken;

  always_comb begin
    perf_stall_d = perf_stall_q + CNT_W'(stall_evt);
    perf_flush_d = perf_flush_q + CNT_W'(flush_evt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.perf_stall = perf_stall_q;
  assign hz.perf_flush = perf_flush_q;
`else
  assign hz.perf_stall = '0;
  assign hz.perf_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed plan scenarios plus randomized traffic vs a cycle model.
module tb_hazard_ctrl;
  localparam int MEM_WAIT_MAX = 16;
  localparam int CNT_W        = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed in terms of observable history.
  bit          m_after_branch;
  int          m_busy_run;
  bit          m_err;
  int unsigned m_stalls;
  int unsigned m_flushes;

  logic [6:0] opcs [8] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011,
                           7'b0000011, 7'b1100111, 7'b0110111, 7'b1101111};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (hz.mem_valid && hz.mem_reg_write && hz.mem_rd != 0 && hz.mem_rd == rs) return 2'b10;
    if (hz.wb_valid && hz.wb_reg_write && hz.wb_rd != 0 && hz.wb_rd == rs)     return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    hz.id_valid = 0; hz.id_opcode = 7'b0010011; hz.id_rs1 = 0; hz.id_rs2 = 0;
    hz.ex_valid = 0; hz.ex_rd = 0; hz.ex_reg_write = 0; hz.ex_mem_read = 0;
    hz.mem_valid = 0; hz.mem_rd = 0; hz.mem_reg_write = 0; hz.branch_taken = 0;
    hz.wb_valid = 0; hz.wb_rd = 0; hz.wb_reg_write = 0; hz.mem_busy = 0;
  endtask

  // Called just after a falling edge with inputs applied: check, clock, advance model.
  task automatic cycle(input string tag);
    bit          r1, r2, lu, stall;
    logic [5:0]  exp_ctrl;
    logic [CNT_W-1:0] exp_ps, exp_pf;
    #1;
    case (hz.id_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin r1 = 1; r2 = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin r1 = 1; r2 = 0; end
      default:                            begin r1 = 0; r2 = 0; end
    endcase
    lu = hz.id_valid && hz.ex_valid && hz.ex_mem_read && hz.ex_rd != 0 &&
         ((r1 && hz.id_rs1 == hz.ex_rd) || (r2 && hz.id_rs2 == hz.ex_rd));
    stall = 0;
    // {pc_en, ifid_en, idex_bubble, flush_ifid, flush_exmem, pipe_freeze}
    if (rst)                           exp_ctrl = 6'b001110;
    else if (hz.branch_taken)          exp_ctrl = 6'b111110;
    else if (hz.mem_busy)              exp_ctrl = 6'b000001;
    else if (lu && !m_after_branch) begin exp_ctrl = 6'b001000; stall = 1; end
    else                               exp_ctrl = 6'b110000;
`ifdef HAZARD_PERF_CNT_EN
    exp_ps = CNT_W'(m_stalls);
    exp_pf = CNT_W'(m_flushes);
`else
    exp_ps = '0;
    exp_pf = '0;
`endif
    check({tag, ".ctrl"}, {hz.pc_en, hz.ifid_en, hz.idex_bubble, hz.flush_ifid,
                           hz.flush_exmem, hz.pipe_freeze}, exp_ctrl);
    check({tag, ".fwd_a"}, hz.fwd_a, rst ? 2'b00 : exp_fwd(hz.id_rs1));
    check({tag, ".fwd_b"}, hz.fwd_b, rst ? 2'b00 : exp_fwd(hz.id_rs2));
    check({tag, ".err"}, hz.err_timeout, m_err);
    check({tag, ".perf_stall"}, hz.perf_stall, exp_ps);
    check({tag, ".perf_flush"}, hz.perf_flush, exp_pf);
    @(posedge clk);
    if (rst) begin
      m_after_branch = 0; m_busy_run = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      m_after_branch = hz.branch_taken;
      if (hz.branch_taken) begin
        m_busy_run = 0;
        m_flushes++;
      end else if (hz.mem_busy) begin
        m_busy_run = (m_busy_run < 255) ? m_busy_run + 1 : 255;
        if (m_busy_run >= MEM_WAIT_MAX) m_err = 1;
      end else begin
        m_busy_run = 0;
      end
      if (stall) m_stalls++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    idle();
    for (int i = 0; i < n; i++) cycle("rst");
    rst = 0;
  endtask

  task automatic set_load_use();
    idle();
    hz.id_valid = 1; hz.id_opcode = 7'b0110011; hz.id_rs1 = 5; hz.id_rs2 = 1;
    hz.ex_valid = 1; hz.ex_rd = 5; hz.ex_reg_write = 1; hz.ex_mem_read = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_after_branch = 0; m_busy_run = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    cycle("rst_hold");
    check("rst_bubble", hz.idex_bubble, 1'b1);
    rst = 0;
    cycle("release");
    check("release_pc_en", hz.pc_en, 1'b1);
    check("release_err", hz.err_timeout, 1'b0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID -> one bubble, then forward from MEM.
    set_load_use();
    #1;
    check("lu_pc_en", hz.pc_en, 1'b0);
    check("lu_bubble", hz.idex_bubble, 1'b1);
    cycle("lu");
    hz.ex_valid = 0; hz.ex_mem_read = 0;
    hz.mem_valid = 1; hz.mem_rd = 5; hz.mem_reg_write = 1;
    #1;
    check("lu_fwd_a", hz.fwd_a, 2'b10);
    check("lu_resume", hz.pc_en, 1'b1);
    cycle("lu_next");

    // MEM beats WB; x0 never forwards.
    idle();
    hz.id_valid = 1; hz.id_opcode = 7'b0110011; hz.id_rs2 = 3;
    hz.mem_valid = 1; hz.mem_reg_write = 1; hz.mem_rd = 3;
    hz.wb_valid = 1; hz.wb_reg_write = 1; hz.wb_rd = 3;
    #1;
    check("fwd_b_mem_prio", hz.fwd_b, 2'b10);
    cycle("fwd_prio");
    hz.id_rs2 = 0; hz.mem_rd = 0; hz.wb_rd = 0;
    #1;
    check("fwd_b_x0", hz.fwd_b, 2'b00);
    cycle("fwd_x0");

    // Branch while LU is live: flush, no stall; next (FLUSH) cycle ignores LU.
    set_load_use();
    hz.branch_taken = 1;
    #1;
    check("br_flush", {hz.flush_ifid, hz.flush_exmem, hz.idex_bubble, hz.pc_en}, 4'b1111);
    cycle("br_lu");
    hz.branch_taken = 0;
    #1;
    check("flush_no_stall", hz.pc_en, 1'b1);
    cycle("flush_lu");

    // Memory wait watchdog.
    do_reset(1);
    idle();
    hz.mem_busy = 1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 16) check("tmo_before", hz.err_timeout, 1'b0);
      if (i == 17) check("tmo_at16", hz.err_timeout, 1'b1);
      cycle("tmo");
    end
    hz.mem_busy = 0;
    cycle("tmo_drop");
    check("tmo_sticky", hz.err_timeout, 1'b1);

    // Perf counters: 3 load-use stalls, 2 taken branches.
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      set_load_use(); cycle("perf_lu");
      idle();         cycle("perf_idle");
    end
    for (int i = 0; i < 2; i++) begin
      idle(); hz.branch_taken = 1; cycle("perf_br");
      idle();                      cycle("perf_idle");
    end
    #1;
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_3", hz.perf_stall, 3);
    check("perf_flush_2", hz.perf_flush, 2);
`else
    check("perf_stall_0", hz.perf_stall, 0);
    check("perf_flush_0", hz.perf_flush, 0);
`endif

    // Randomized traffic against the model.
    do_reset(1);
    for (int n = 0; n < 2000; n++) begin
      rst              = ($urandom_range(0, 199) == 0);
      hz.id_valid      = ($urandom_range(0, 7) != 0);
      hz.id_opcode     = opcs[$urandom_range(0, 7)];
      hz.id_rs1        = 5'($urandom_range(0, 3));
      hz.id_rs2        = 5'($urandom_range(0, 3));
      hz.ex_valid      = ($urandom_range(0, 3) != 0);
      hz.ex_rd         = 5'($urandom_range(0, 3));
      hz.ex_reg_write  = 1'($urandom_range(0, 1));
      hz.ex_mem_read   = 1'($urandom_range(0, 1));
      hz.mem_valid     = ($urandom_range(0, 3) != 0);
      hz.mem_rd        = 5'($urandom_range(0, 3));
      hz.mem_reg_write = 1'($urandom_range(0, 1));
      hz.wb_valid      = ($urandom_range(0, 3) != 0);
      hz.wb_rd         = 5'($urandom_range(0, 3));
      hz.wb_reg_write  = 1'($urandom_range(0, 1));
      hz.branch_taken  = ($urandom_range(0, 7) == 0);
      hz.mem_busy      = (n % 400 > 370) ? 1'b1 : ($urandom_range(0, 4) == 0);
      cycle("rand");
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline interlock controller for the five-stage RV32I core. It compares the decode-stage source registers against in-flight destinations and drives the pipeline-register enables, bubble/flush controls and operand forwarding selects. A small FSM sequences load-use stalls, taken-branch flushes and data-memory wait freezes, with a watchdog on memory wait.

Parameters:
MEM_WAIT_MAX, 16, max consecutive mem_busy cycles before err_timeout; legal range 1..255
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  7  ID instruction[6:0]
id_rs1  in  5  ID instruction[19:15]
id_rs2  in  5  ID instruction[24:20]
ex_valid  in  1  EX stage valid
ex_rd  in  5  EX destination
ex_reg_write  in  1  EX CRT_WB[0]
ex_mem_read  in  1  EX CRT_MEM[1]
mem_valid  in  1  MEM stage valid
mem_rd  in  5  MEM destination
mem_reg_write  in  1  MEM CRT_WB[0]
branch_taken  in  1  MEM branch resolved taken (Branch & condition)
wb_valid  in  1  WB stage valid
wb_rd  in  5  WB destination
wb_reg_write  in  1  WB CRT_WB[0]
mem_busy  in  1  data memory not ready
pc_en  out  1  PC register enable
ifid_en  out  1  IF/ID enable
idex_bubble  out  1  load NOP into ID/EX
flush_ifid  out  1  clear IF/ID
flush_exmem  out  1  clear EX/MEM
pipe_freeze  out  1  hold all pipeline registers
fwd_a  out  2  rs1 select: 00 regfile, 10 MEM-stage result, 01 WB-stage result
fwd_b  out  2  rs2 select, same encoding
err_timeout  out  1  sticky memory-wait timeout
perf_stall  out  CNT_W  load-use stall cycles (optional feature)
perf_flush  out  CNT_W  taken-branch flushes (optional feature)

Behaviour:
- Clock clk, reset rst: one clock; reset synchronous, active-high.
- Reset (rst sampled high): state=RUN, wait counter=0, err_timeout=0, perf counters=0. While rst is high: pc_en=0, ifid_en=0, idex_bubble=1, flush_ifid=1, flush_exmem=1, pipe_freeze=0, fwd_a=fwd_b=00.
- Source usage by opcode: R 0110011, S 0100011, B 1100011 use rs1+rs2; OP-IMM 0010011, LOAD 0000011, JALR 1100111 use rs1 only; LUI, AUIPC, JAL and all others use none.
- Forwarding (combinational): for rs1, if mem_valid & mem_reg_write & mem_rd!=0 & mem_rd==id_rs1 -> 10; else if wb_valid & wb_reg_write & wb_rd!=0 & wb_rd==id_rs1 -> 01; else 00. MEM has priority over WB. Same rule for rs2. x0 is never forwarded.
- Load-use hazard (LU): id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((use_rs1 & id_rs1==ex_rd) | (use_rs2 & id_rs2==ex_rd)).
- Control outputs are combinational from the state and inputs. Priority is branch_taken > mem_busy > LU.
- FSM states RUN, LD_STALL, FLUSH, MEM_WAIT. Next-state rules:
  - branch_taken -> FLUSH, from any state (including MEM_WAIT).
  - else mem_busy -> MEM_WAIT.
  - else LU and state!=FLUSH -> LD_STALL.
  - else RUN.
- branch_taken cycle: flush_ifid=1, idex_bubble=1, flush_exmem=1, pc_en=1, ifid_en=1. perf_flush increments.
- FLUSH: lasts one cycle; LU is suppressed; all enables 1; no bubbles.
- mem_busy cycle: pipe_freeze=1, pc_en=0, ifid_en=0, no bubble/flush. The wait counter increments and saturates at 255. When the counter reaches MEM_WAIT_MAX, err_timeout is set. The counter clears on the first cycle with mem_busy=0.
- LU cycle: pc_en=0, ifid_en=0, idex_bubble=1 for exactly one cycle; perf_stall increments. In the following cycle the load is in MEM, and forwarding selects 10 only if the MEM-stage value is valid. A back-to-back dependent pair costs exactly one bubble.
- Otherwise: pc_en=1, ifid_en=1, all bubble/flush/freeze outputs 0.
- Simultaneous branch_taken & mem_busy: the flush wins. Memory wait for the flushed instruction is abandoned; the MEM stage re-raises mem_busy if it is still needed.
- Perf counters wrap modulo 2^CNT_W.

Optional Feature:
HAZARD_PERF_CNT_EN: when defined, perf_stall and perf_flush are live counters as described. When undefined, both ports are constant 0 and no counter flops are instantiated. The ports exist in both builds.

Decomposition:
- Package hazard_pkg holds: opcode localparams, the fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), the hz_state_t enum, and the function uses_rs(opcode) returning {use_rs1,use_rs2}.
- One sub-module, fwd_sel, is instantiated twice (rs1, rs2) and computes one forwarding select.

Test Plan:
- rst held 3 cycles -> idex_bubble=1, flush_ifid=1, pc_en=0; release -> state RUN, pc_en=1, err_timeout=0.
- EX: lw x5 (ex_mem_read=1, ex_rd=5); ID: add x6,x5,x1 -> one cycle pc_en=0, idex_bubble=1. Next cycle mem_rd=5 -> fwd_a=10, pc_en=1.
- MEM rd=3 and WB rd=3 both writing, ID rs2=3 -> fwd_b=10. Same with rd=0 -> fwd_b=00.
- branch_taken=1 while LU is true -> flush_ifid=flush_exmem=idex_bubble=1, no stall; next cycle (FLUSH) LU is ignored.
- mem_busy high 20 cycles with MEM_WAIT_MAX=16 -> pipe_freeze=1 throughout; err_timeout rises on the 16th cycle and stays high after mem_busy drops.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls plus 2 taken branches -> perf_stall=3, perf_flush=2. Without the macro, both read 0.
